// File: rtl/draw_tri_sched.sv
`default_nettype none
// ============================================================================
//  Module   : draw_tri_sched
//  Purpose  : Queues triangle-draw requests (16-bit edge-table addresses)
//             and issues them one at a time to the triangle fetch engine
//             as a single-cycle start pulse followed by a BUSY handshake.
//             Watches for a missing acknowledge or a hung engine and
//             reports sticky errors.
//  Options  : DRAW_SCHED_STATS_EN adds saturating issue/drop counters.
//  Revision : 1.0  initial release
// ============================================================================
module draw_tri_sched #(
    parameter int QDEPTH       = 8,
    parameter int ACK_TIMEOUT  = 4,
    parameter int DONE_TIMEOUT = 256
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic                      cmd_valid,
    input  logic [15:0]               cmd_edge_addr,
    output logic                      cmd_ready,
    output logic                      draw_req_pulse,
    output logic [15:0]               edge_addr,
    input  logic                      eng_busy,
    output logic [$clog2(QDEPTH):0]   q_level,
    output logic                      q_empty,
    output logic                      q_full,
    output logic                      idle,
    output logic                      drop_pulse,
    output logic                      err_ack,
    output logic                      err_hang,
    input  logic                      err_clr
`ifdef DRAW_SCHED_STATS_EN
    ,
    output logic [15:0]               stat_issued,
    output logic [15:0]               stat_dropped
`endif
);

    localparam int C_PW   = $clog2(QDEPTH);
    localparam int C_LW   = C_PW + 1;
    localparam int C_TMAX = (DONE_TIMEOUT > ACK_TIMEOUT) ? DONE_TIMEOUT : ACK_TIMEOUT;
    localparam int C_TW   = $clog2(C_TMAX + 1);

    localparam logic [C_LW-1:0] C_DEPTH     = C_LW'(QDEPTH);
    localparam logic [C_TW-1:0] C_ACK_LAST  = C_TW'(ACK_TIMEOUT - 1);
    localparam logic [C_TW-1:0] C_DONE_LAST = C_TW'(DONE_TIMEOUT - 1);
    localparam logic [C_TW-1:0] C_DONE_SAT  = C_TW'(DONE_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [15:0]       r_mem [QDEPTH];
    logic [C_PW-1:0]   r_wr_ptr;
    logic [C_PW-1:0]   r_rd_ptr;
    logic [C_LW-1:0]   r_level;
    logic [C_TW-1:0]   r_timer;
    logic [C_TW-1:0]   w_next_timer;
    logic              r_pulse;
    logic [15:0]       r_edge_addr;
    logic              r_drop;
    logic              r_err_ack;
    logic              r_err_hang;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_issue;
    logic              w_set_ack;
    logic              w_set_hang;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == C_DEPTH);
    assign w_push  = cmd_valid && !w_full;
    assign w_drop  = cmd_valid && w_full;
    assign w_pop   = w_issue && !w_empty;

    // State register
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, timer and event decode. The acknowledge window covers the
    // pulse cycle and the three cycles after it; the hang timer saturates.
    always_comb begin
        w_next_state = r_state;
        w_next_timer = '0;
        w_issue      = 1'b0;
        w_set_ack    = 1'b0;
        w_set_hang   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A foreign start (eng_busy already high) holds us here.
                if (!w_empty && !eng_busy) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_issue      = 1'b1;
                w_next_state = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (eng_busy) begin
                    w_next_state = ST_WAIT_DONE;
                end else if (r_timer == C_ACK_LAST) begin
                    // No retry: the request is dropped on a missing acknowledge.
                    w_set_ack    = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_timer = r_timer + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!eng_busy) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_timer = (r_timer == C_DONE_SAT) ? r_timer : r_timer + 1'b1;
                    w_set_hang   = (r_timer == C_DONE_LAST);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FIFO storage; contents are only ever qualified by the pointers
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_edge_addr;
        end
    end

    // FIFO pointers and occupancy; pointers wrap modulo the depth
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Registered engine interface, timer, drop strobe and sticky errors
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_timer     <= '0;
            r_pulse     <= 1'b0;
            r_edge_addr <= '0;
            r_drop      <= 1'b0;
            r_err_ack   <= 1'b0;
            r_err_hang  <= 1'b0;
        end else begin
            r_timer <= w_next_timer;
            r_pulse <= w_issue;
            r_drop  <= w_drop;
            if (w_issue) begin
                r_edge_addr <= r_mem[r_rd_ptr];
            end
            if (err_clr) begin
                r_err_ack  <= 1'b0;
                r_err_hang <= 1'b0;
            end else begin
                if (w_set_ack) begin
                    r_err_ack <= 1'b1;
                end
                if (w_set_hang) begin
                    r_err_hang <= 1'b1;
                end
            end
        end
    end

`ifdef DRAW_SCHED_STATS_EN
    logic [15:0] r_stat_issued;
    logic [15:0] r_stat_dropped;

    // Saturating issue/drop counters, cleared together with the errors
    always_ff @(posedge CLK) begin
        if (rst || err_clr) begin
            r_stat_issued  <= '0;
            r_stat_dropped <= '0;
        end else begin
            if (w_issue && (r_stat_issued != 16'hFFFF)) begin
                r_stat_issued <= r_stat_issued + 16'd1;
            end
            if (w_drop && (r_stat_dropped != 16'hFFFF)) begin
                r_stat_dropped <= r_stat_dropped + 16'd1;
            end
        end
    end

    assign stat_issued  = r_stat_issued;
    assign stat_dropped = r_stat_dropped;
`endif

    assign cmd_ready      = !w_full;
    assign draw_req_pulse = r_pulse;
    assign edge_addr      = r_edge_addr;
    assign q_level        = r_level;
    assign q_empty        = w_empty;
    assign q_full         = w_full;
    assign idle           = (r_state == ST_IDLE) && w_empty && !eng_busy;
    assign drop_pulse     = r_drop;
    assign err_ack        = r_err_ack;
    assign err_hang       = r_err_hang;

endmodule
`default_nettype wire

// File: tb/tb_draw_tri_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_draw_tri_sched
//  Purpose  : Self-checking bench for draw_tri_sched: a per-cycle vector
//             table for a single transaction, then directed sequences for
//             queue-full drops, acknowledge timeout, hang timeout, reset
//             mid-transfer and (with DRAW_SCHED_STATS_EN) the counters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_draw_tri_sched;

    localparam int QD = 8;

    logic        CLK = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [15:0] cmd_edge_addr;
    logic        cmd_ready;
    logic        draw_req_pulse;
    logic [15:0] edge_addr;
    logic        eng_busy;
    logic [3:0]  q_level;
    logic        q_empty;
    logic        q_full;
    logic        idle;
    logic        drop_pulse;
    logic        err_ack;
    logic        err_hang;
    logic        err_clr;
`ifdef DRAW_SCHED_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_dropped;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] seen[$];

    typedef struct {
        logic        valid;
        logic [15:0] addr;
        logic        busy;
        logic        clr;
        logic        pulse;
        logic [15:0] eaddr;
        logic [3:0]  level;
        logic        idl;
        logic        drop;
        logic        ack;
        logic        hang;
    } vec_t;

    vec_t vecs[$];

    draw_tri_sched #(.QDEPTH(QD), .ACK_TIMEOUT(4), .DONE_TIMEOUT(256)) u_dut (
        .CLK            (CLK),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_edge_addr  (cmd_edge_addr),
        .cmd_ready      (cmd_ready),
        .draw_req_pulse (draw_req_pulse),
        .edge_addr      (edge_addr),
        .eng_busy       (eng_busy),
        .q_level        (q_level),
        .q_empty        (q_empty),
        .q_full         (q_full),
        .idle           (idle),
        .drop_pulse     (drop_pulse),
        .err_ack        (err_ack),
        .err_hang       (err_hang),
        .err_clr        (err_clr)
`ifdef DRAW_SCHED_STATS_EN
        ,
        .stat_issued    (stat_issued),
        .stat_dropped   (stat_dropped)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [15:0] a, input logic b, input logic c,
                                input logic p, input logic [15:0] ea, input logic [3:0] lv,
                                input logic il, input logic dr, input logic ak, input logic hg);
        vec_t t;
        t.valid = v;  t.addr = a;   t.busy = b;   t.clr = c;
        t.pulse = p;  t.eaddr = ea; t.level = lv; t.idl = il;
        t.drop = dr;  t.ack = ak;   t.hang = hg;
        return t;
    endfunction

    // Respond to n pulses: raise eng_busy during the pulse cycle, hold it for
    // 'hold' cycles, then drop it; records each issued address in order.
    task automatic service(input int n, input int hold);
        int got   = 0;
        int gap   = 0;
        bit first = 1'b1;
        for (int cyc = 0; cyc < 2000 && got < n; cyc++) begin
            tick();
            gap++;
            if (draw_req_pulse) begin
                seen.push_back(edge_addr);
                if (!first) begin
                    check("b2b_gap_ge2", 32'(gap >= 2), 32'd1);
                end
                first = 1'b0;
                got++;
                eng_busy = 1'b1;
                for (int h = 0; h < hold; h++) begin
                    tick();
                    check("no_pulse_while_busy", 32'(draw_req_pulse), 32'd0);
                end
                eng_busy = 1'b0;
                gap = 0;
            end
        end
        check("service_count", 32'(got), 32'(n));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [27:0] act_v;
        logic [27:0] exp_v;
        int          pc;

        rst = 1'b1; cmd_valid = 1'b0; cmd_edge_addr = '0; eng_busy = 1'b0; err_clr = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_level",     32'(q_level),        32'd0);
        check("rst_empty",     32'(q_empty),        32'd1);
        check("rst_full",      32'(q_full),         32'd0);
        check("rst_ready",     32'(cmd_ready),      32'd1);
        check("rst_idle",      32'(idle),           32'd1);
        check("rst_pulse",     32'(draw_req_pulse), 32'd0);
        check("rst_edge_addr", 32'(edge_addr),      32'd0);
        check("rst_errs",      32'({drop_pulse, err_ack, err_hang}), 32'd0);
        rst = 1'b0;

        // Single transaction: accept, ISSUE, pulse 2 edges after accept,
        // busy from the cycle after the pulse for 9 cycles, then idle.
        vecs.push_back(mk(1, 16'h0012, 0, 0,  0, 16'h0000, 4'd1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0,  0, 16'h0000, 4'd1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0,  1, 16'h0012, 4'd0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0,  0, 16'h0012, 4'd0, 0, 0, 0, 0));
        for (int i = 0; i < 9; i++) begin
            vecs.push_back(mk(0, 16'h0000, 1, 0,  0, 16'h0012, 4'd0, 0, 0, 0, 0));
        end
        vecs.push_back(mk(0, 16'h0000, 0, 0,  0, 16'h0012, 4'd0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 1,  0, 16'h0012, 4'd0, 1, 0, 0, 0));

        foreach (vecs[i]) begin
            cmd_valid     = vecs[i].valid;
            cmd_edge_addr = vecs[i].addr;
            eng_busy      = vecs[i].busy;
            err_clr       = vecs[i].clr;
            tick();
            exp_v = {vecs[i].pulse, vecs[i].eaddr, vecs[i].level,
                     (vecs[i].level == 4'd0), (vecs[i].level == 4'(QD)), (vecs[i].level != 4'(QD)),
                     vecs[i].idl, vecs[i].drop, vecs[i].ack, vecs[i].hang};
            act_v = {draw_req_pulse, edge_addr, q_level, q_empty, q_full, cmd_ready,
                     idle, drop_pulse, err_ack, err_hang};
            check($sformatf("vec%0d", i), 32'(act_v), 32'(exp_v));
        end
        err_clr = 1'b0;

        // Fill while a foreign start holds eng_busy, then drop a 9th request
        eng_busy = 1'b1;
        pc = 0;
        for (int i = 1; i <= 8; i++) begin
            cmd_valid = 1'b1;
            cmd_edge_addr = 16'(i);
            tick();
            if (draw_req_pulse) pc++;
        end
        check("fill_no_pulse", 32'(pc), 32'd0);
        check("fill_level",    32'(q_level),   32'd8);
        check("fill_full",     32'(q_full),    32'd1);
        check("fill_ready",    32'(cmd_ready), 32'd0);
        cmd_edge_addr = 16'h0009;
        tick();
        check("drop_pulse_hi", 32'(drop_pulse), 32'd1);
        check("drop_level",    32'(q_level),    32'd8);
        cmd_valid = 1'b0;
        tick();
        check("drop_pulse_lo", 32'(drop_pulse), 32'd0);
        eng_busy = 1'b0;
        seen.delete();
        service(8, 3);
        foreach (seen[i]) begin
            check($sformatf("order%0d", i), 32'(seen[i]), 32'(i + 1));
        end
        tick();
        tick();
        check("order_idle", 32'(idle), 32'd1);

        // Acknowledge timeout drops the head, then the next entry issues
        cmd_valid = 1'b1; cmd_edge_addr = 16'h0030;
        tick();
        cmd_edge_addr = 16'h0031;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("ack_pulse1", 32'({draw_req_pulse, edge_addr}), 32'h1_0030);
        tick(); tick(); tick();
        check("ack_not_yet", 32'(err_ack), 32'd0);
        tick();
        check("ack_set", 32'(err_ack), 32'd1);
        tick();
        check("ack_no_pulse", 32'(draw_req_pulse), 32'd0);
        tick();
        check("ack_pulse2", 32'({draw_req_pulse, edge_addr}), 32'h1_0031);
        tick(); tick(); tick();
        check("ack_wait_not_idle", 32'(idle), 32'd0);
        tick();
        check("ack_back_idle", 32'(idle), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ack_clr", 32'(err_ack), 32'd0);

        // Hang: busy held 300 cycles, flag after 256 cycles in WAIT_DONE
        cmd_valid = 1'b1; cmd_edge_addr = 16'h0040;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("hang_pulse", 32'({draw_req_pulse, edge_addr}), 32'h1_0040);
        eng_busy = 1'b1;
        pc = 0;
        for (int t = 1; t <= 300; t++) begin
            tick();
            if (draw_req_pulse) pc++;
            if (t == 256) check("hang_not_yet", 32'(err_hang), 32'd0);
            if (t == 257) check("hang_set",     32'(err_hang), 32'd1);
        end
        check("hang_no_pulse", 32'(pc), 32'd0);
        eng_busy = 1'b0;
        tick();
        check("hang_idle", 32'({idle, err_hang}), 32'b11);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("hang_clr", 32'(err_hang), 32'd0);

        // Reset while in WAIT_DONE with 3 entries queued and err_ack set
        cmd_valid = 1'b1; cmd_edge_addr = 16'h004F;
        tick();
        cmd_valid = 1'b0;
        for (int t = 0; t < 6; t++) tick();
        check("rst_pre_ack", 32'(err_ack), 32'd1);
        cmd_valid = 1'b1; cmd_edge_addr = 16'h0050;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("rst_pulse50", 32'({draw_req_pulse, edge_addr}), 32'h1_0050);
        eng_busy = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            cmd_valid = 1'b1;
            cmd_edge_addr = 16'(16'h0050 + i);
            tick();
        end
        cmd_valid = 1'b0;
        check("rst_pre_level", 32'(q_level), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_level", 32'(q_level), 32'd0);
        check("rst_mid_flags", 32'({q_empty, cmd_ready, err_ack, err_hang, draw_req_pulse}), 32'b11000);
        pc = 0;
        for (int t = 0; t < 3; t++) begin
            tick();
            if (draw_req_pulse) pc++;
        end
        eng_busy = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (draw_req_pulse) pc++;
        end
        check("rst_mid_no_pulse", 32'(pc), 32'd0);
        check("rst_mid_idle",     32'(idle), 32'd1);

`ifdef DRAW_SCHED_STATS_EN
        // Counters: 5 issues, then 2 drops against a full queue
        do_reset();
        check("stat_rst", 32'({stat_issued, stat_dropped}), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_edge_addr = 16'(16'h0100 + i);
            tick();
        end
        cmd_valid = 1'b0;
        service(4, 2);
        service(1, 2);
        tick();
        tick();
        check("stat_issued5", 32'(stat_issued), 32'd5);
        eng_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cmd_valid = 1'b1;
            cmd_edge_addr = 16'(16'h0200 + i);
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        check("stat_dropped2", 32'(stat_dropped), 32'd2);
        check("stat_issued_hold", 32'(stat_issued), 32'd5);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("stat_clr", 32'({stat_issued, stat_dropped}), 32'd0);
        eng_busy = 1'b0;
        do_reset();
`else
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
